// File: rtl/alu_cmd_dispatcher_pkg.sv
// Shared definitions for the ALU command dispatcher: field widths, opcode
// encodings understood by alu_top, and the dispatcher FSM states.
package alu_cmd_dispatcher_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV = 3'b011;
  localparam logic [OP_W-1:0] OP_AND = 3'b100;
  localparam logic [OP_W-1:0] OP_OR  = 3'b101;
  localparam logic [OP_W-1:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_cmd_dispatcher_if.sv
// Command, ALU-issue and response channels of the dispatcher. The dispatcher
// connects through the slave modport; its environment uses master.
interface alu_cmd_dispatcher_if
  import alu_cmd_dispatcher_pkg::*;
#(
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 4
);

  logic                               cmd_valid;
  logic                               cmd_ready;
  logic [OP_W-1:0]                    cmd_op;
  logic [DATA_W-1:0]                  cmd_a;
  logic [DATA_W-1:0]                  cmd_b;
  logic [TAG_W-1:0]                   cmd_tag;

  logic                               alu_start;
  logic [OP_W-1:0]                    alu_op;
  logic [DATA_W-1:0]                  alu_a;
  logic [DATA_W-1:0]                  alu_b;
  logic                               alu_done;
  logic [RES_W-1:0]                   alu_result;

  logic                               rsp_valid;
  logic                               rsp_ready;
  logic [RES_W-1:0]                   rsp_result;
  logic [OP_W-1:0]                    rsp_op;
  logic [TAG_W-1:0]                   rsp_tag;
  logic                               rsp_timeout;

  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
    output cmd_ready,
    output alu_start, alu_op, alu_a, alu_b,
    input  alu_done, alu_result,
    output rsp_valid, rsp_result, rsp_op, rsp_tag, rsp_timeout,
    input  rsp_ready,
    output fifo_count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
    input  cmd_ready,
    input  alu_start, alu_op, alu_a, alu_b,
    output alu_done, alu_result,
    input  rsp_valid, rsp_result, rsp_op, rsp_tag, rsp_timeout,
    output rsp_ready,
    input  fifo_count
  );

endinterface

// File: rtl/alu_cmd_dispatcher_fifo.sv
// Synchronous show-ahead FIFO holding packed commands; the head entry is
// visible on rdata whenever the FIFO is non-empty.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 23
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage is deliberately left out of reset; only pointers and count
  // define validity, and a resettable array would cost a flop-reset per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/alu_cmd_dispatcher.sv
// Queues tagged ALU commands, issues them one at a time to alu_top and
// returns result plus tag, or a timeout if the ALU never reports done.
module alu_cmd_dispatcher
  import alu_cmd_dispatcher_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_cmd_dispatcher_if.slave  bus
);

  localparam int CMD_W  = OP_W + 2*DATA_W + TAG_W;
  localparam int CNT_W  = $clog2(TIMEOUT);
  localparam int FCNT_W = $clog2(FIFO_DEPTH+1);

  state_t              state_q;
  state_t              state_d;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [CMD_W-1:0]    head;
  logic [FCNT_W-1:0]   count;

  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [TAG_W-1:0]    tag_q;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic [RES_W-1:0]    rsp_result_q;
  logic                rsp_timeout_q;
  logic                wait_expired;

  assign push         = bus.cmd_valid && !full;
  assign pop          = (state_q == ST_IDLE) && !empty;
  assign wait_expired = (wait_cnt_q == CNT_W'(TIMEOUT-1));

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_tag}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // NOTE: clocked state uses <= so every flop samples pre-edge values,
  // independent of the order the always_ff blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the default assignment up front keeps every path driven, so no
  // latch is inferred for state_d.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!empty) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (bus.alu_done || wait_expired) state_d = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Done is only looked at in WAIT, so a level left over from a previous
  // command cannot complete the one just issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      tag_q         <= '0;
      wait_cnt_q    <= '0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (pop) {op_q, a_q, b_q, tag_q} <= head;
      if (state_q == ST_ISSUE)     wait_cnt_q <= '0;
      else if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
      if (state_q == ST_WAIT) begin
        if (bus.alu_done) begin
          rsp_result_q  <= bus.alu_result;
          rsp_timeout_q <= 1'b0;
        end else if (wait_expired) begin
          rsp_result_q  <= '0;
          rsp_timeout_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.alu_start = (state_q == ST_ISSUE);
    bus.rsp_valid = (state_q == ST_RESP);
    bus.cmd_ready = !full;
  end

  assign bus.alu_op      = op_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_op      = op_q;
  assign bus.rsp_tag     = tag_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.fifo_count  = count;

endmodule

// File: tb/tb_alu_cmd_dispatcher.sv
// Bench for alu_cmd_dispatcher: an ALU stub with selectable behaviour,
// table vectors, directed corner sequences and a randomized scoreboard run.
module tb_alu_cmd_dispatcher;
  import alu_cmd_dispatcher_pkg::*;

  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_cmd_dispatcher_if #(.TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) bus ();

  alu_cmd_dispatcher #(
    .FIFO_DEPTH (DEPTH),
    .TAG_W      (TAG_W),
    .TIMEOUT    (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ALU behaviour as seen by the dispatcher
  function automatic logic [15:0] alu_ref(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      OP_ADD:  return 16'(a) + 16'(b);
      OP_SUB:  return 16'(a) - 16'(b);
      OP_MUL:  return 16'(a) * 16'(b);
      OP_DIV:  return (b == 8'd0) ? 16'hFFFF : 16'(a / b);
      OP_AND:  return {8'h00, a & b};
      OP_OR:   return {8'h00, a | b};
      OP_XOR:  return {8'h00, a ^ b};
      default: return {a, b};
    endcase
  endfunction

  typedef enum int {STUB_NORMAL, STUB_NEVER, STUB_ALWAYS} stub_mode_t;
  stub_mode_t  mode = STUB_NORMAL;
  int          fixed_lat = -1;
  logic        stub_busy;
  int          stub_lat;
  logic        stub_done;
  logic [15:0] stub_res;

  always @(posedge clk) begin
    if (reset) begin
      stub_busy <= 1'b0;
      stub_done <= 1'b0;
      stub_lat  <= 0;
      stub_res  <= 16'h0;
    end else begin
      stub_done <= 1'b0;
      if (bus.alu_start) begin
        stub_busy <= 1'b1;
        stub_lat  <= (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
        stub_res  <= alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
      end else if (stub_busy) begin
        if (stub_lat == 0) begin
          stub_done <= 1'b1;
          stub_busy <= 1'b0;
        end else begin
          stub_lat <= stub_lat - 1;
        end
      end
    end
  end

  assign bus.alu_done   = (mode == STUB_ALWAYS) ? 1'b1 :
                          (mode == STUB_NEVER)  ? 1'b0 : stub_done;
  assign bus.alu_result = (mode == STUB_ALWAYS) ? alu_ref(bus.alu_op, bus.alu_a, bus.alu_b)
                                                : stub_res;

  int   n_start = 0;
  int   n_double = 0;
  logic prev_start = 1'b0;
  always @(posedge clk) begin
    if (bus.alu_start) n_start <= n_start + 1;
    if (bus.alu_start && prev_start) n_double <= n_double + 1;
    prev_start <= bus.alu_start;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push_cmd(logic [2:0] op, logic [7:0] a, logic [7:0] b, logic [TAG_W-1:0] tag);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_tag   = tag;
    for (int i = 0; i < 300; i++) begin
      if (bus.cmd_ready) begin
        step();
        bus.cmd_valid = 1'b0;
        return;
      end
      step();
    end
    check("push_accept", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(string name, logic [2:0] op, logic [TAG_W-1:0] tag,
                            logic [15:0] res, logic tmo);
    logic old_ready;
    for (int i = 0; i < 300 && !bus.rsp_valid; i++) step();
    check({name, "_valid"},   32'(bus.rsp_valid),   32'd1);
    check({name, "_result"},  32'(bus.rsp_result),  32'(res));
    check({name, "_tag"},     32'(bus.rsp_tag),     32'(tag));
    check({name, "_op"},      32'(bus.rsp_op),      32'(op));
    check({name, "_timeout"}, 32'(bus.rsp_timeout), 32'(tmo));
    old_ready     = bus.rsp_ready;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = old_ready;
  endtask

  typedef struct {
    logic [2:0]       op;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
    logic [15:0]      exp;
  } vec_t;

  typedef struct {
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic [15:0]      result;
    logic             timeout;
  } rsp_t;

  vec_t vecs [10];
  rsp_t exp_q [$];

  initial begin
    int s0;
    int k;
    int seen;
    int accepted;
    logic [15:0]      hold_res;
    logic [TAG_W-1:0] hold_tag;
    rsp_t e;

    vecs[0] = '{OP_ADD, 8'd25,  8'd17,  4'd3,  16'd42};
    vecs[1] = '{OP_SUB, 8'd42,  8'd15,  4'd5,  16'd27};
    vecs[2] = '{OP_MUL, 8'd6,   8'd9,   4'd6,  16'd54};
    vecs[3] = '{OP_DIV, 8'd100, 8'd4,   4'd7,  16'd25};
    vecs[4] = '{OP_XOR, 8'hAA,  8'hCC,  4'd8,  16'h0066};
    vecs[5] = '{OP_AND, 8'hF0,  8'h3C,  4'd9,  16'h0030};
    vecs[6] = '{OP_OR,  8'h0F,  8'hF0,  4'hA,  16'h00FF};
    vecs[7] = '{OP_MUL, 8'hFF,  8'hFF,  4'hB,  16'hFE01};
    vecs[8] = '{3'b111, 8'h12,  8'h34,  4'hC,  16'h1234};
    vecs[9] = '{OP_SUB, 8'd0,   8'd1,   4'hD,  16'hFFFF};

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b1;
    step(3);
    reset = 1'b0;

    // Reset state
    check("rst_cmd_ready",  32'(bus.cmd_ready),   32'd1);
    check("rst_rsp_valid",  32'(bus.rsp_valid),   32'd0);
    check("rst_alu_start",  32'(bus.alu_start),   32'd0);
    check("rst_fifo_count", 32'(bus.fifo_count),  32'd0);
    check("rst_alu_ops",    {8'h0, 5'(bus.alu_op), bus.alu_a, bus.alu_b, 3'h0}, 32'd0);
    check("rst_rsp_fields", {bus.rsp_result, 8'(bus.rsp_tag), 4'(bus.rsp_op), 4'(bus.rsp_timeout)}, 32'd0);

    // Single ADD: start pulse two cycles after the push edge
    s0 = n_start;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_a     = 8'd25;
    bus.cmd_b     = 8'd17;
    bus.cmd_tag   = 4'd3;
    step();
    bus.cmd_valid = 1'b0;
    check("lat_start_n1", 32'(bus.alu_start),  32'd0);
    check("lat_count_n1", 32'(bus.fifo_count), 32'd1);
    step();
    check("lat_start_n2", 32'(bus.alu_start),  32'd1);
    check("lat_operands", {8'h0, 5'(bus.alu_op), bus.alu_a, bus.alu_b, 3'h0},
          {8'h0, 5'(OP_ADD), 8'd25, 8'd17, 3'h0});
    step();
    check("lat_start_n3", 32'(bus.alu_start),  32'd0);
    expect_rsp("add", OP_ADD, 4'd3, 16'd42, 1'b0);
    check("add_one_start", 32'(n_start - s0), 32'd1);

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      push_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      expect_rsp($sformatf("vec%0d", i), vecs[i].op, vecs[i].tag, vecs[i].exp, 1'b0);
    end

    // Stall in RESP, fill the FIFO, check stability and ordering
    bus.rsp_ready = 1'b0;
    push_cmd(OP_ADD, 8'd1, 8'd1, 4'hF);
    for (int i = 0; i < 100 && !bus.rsp_valid; i++) step();
    push_cmd(OP_SUB, 8'd42,  8'd15,  4'd1);
    push_cmd(OP_MUL, 8'd6,   8'd9,   4'd2);
    push_cmd(OP_DIV, 8'd100, 8'd4,   4'd3);
    push_cmd(OP_XOR, 8'hAA,  8'hCC,  4'd4);
    check("full_cmd_ready",  32'(bus.cmd_ready),  32'd0);
    check("full_fifo_count", 32'(bus.fifo_count), 32'd4);
    hold_res = bus.rsp_result;
    hold_tag = bus.rsp_tag;
    s0 = n_start;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_valid",  32'(bus.rsp_valid), 32'd1);
      check("hold_fields", {bus.rsp_result, 12'h0, 4'(bus.rsp_tag)}, {hold_res, 12'h0, 4'(hold_tag)});
    end
    check("hold_no_start", 32'(n_start - s0), 32'd0);
    expect_rsp("q_add", OP_ADD, 4'hF, 16'd2,    1'b0);
    expect_rsp("q_sub", OP_SUB, 4'd1, 16'd27,   1'b0);
    expect_rsp("q_mul", OP_MUL, 4'd2, 16'd54,   1'b0);
    expect_rsp("q_div", OP_DIV, 4'd3, 16'd25,   1'b0);
    expect_rsp("q_xor", OP_XOR, 4'd4, 16'h0066, 1'b0);
    bus.rsp_ready = 1'b1;

    // ALU never completes: timeout exactly TMO cycles after entering WAIT
    mode = STUB_NEVER;
    push_cmd(OP_MUL, 8'd3, 8'd4, 4'd6);
    for (int i = 0; i < 10 && !bus.alu_start; i++) step();
    k = 0;
    while (!bus.rsp_valid && k < 3*TMO) begin
      step();
      k++;
    end
    check("tmo_cycles", 32'(k), 32'(TMO + 1));
    expect_rsp("tmo", OP_MUL, 4'd6, 16'd0, 1'b1);

    // Done on the last allowed cycle wins; one cycle later is a timeout
    mode      = STUB_NORMAL;
    fixed_lat = TMO - 2;
    push_cmd(OP_ADD, 8'd7, 8'd8, 4'd1);
    expect_rsp("edge_done", OP_ADD, 4'd1, 16'd15, 1'b0);
    fixed_lat = TMO - 1;
    push_cmd(OP_ADD, 8'd7, 8'd9, 4'd2);
    expect_rsp("edge_late", OP_ADD, 4'd2, 16'd0, 1'b1);
    fixed_lat = -1;

    // Done held high: one start and one response per command, order kept
    mode = STUB_ALWAYS;
    s0 = n_start;
    bus.rsp_ready = 1'b0;
    push_cmd(OP_ADD, 8'd10, 8'd20, 4'd1);
    push_cmd(OP_SUB, 8'd50, 8'd8,  4'd2);
    push_cmd(OP_OR,  8'h81, 8'h18, 4'd3);
    expect_rsp("dh0", OP_ADD, 4'd1, 16'd30,   1'b0);
    expect_rsp("dh1", OP_SUB, 4'd2, 16'd42,   1'b0);
    expect_rsp("dh2", OP_OR,  4'd3, 16'h0099, 1'b0);
    bus.rsp_ready = 1'b1;
    step(2);
    check("dh_starts", 32'(n_start - s0), 32'd3);

    // Reset in WAIT with two queued: everything abandoned
    mode = STUB_NEVER;
    push_cmd(OP_ADD, 8'd1, 8'd2, 4'd1);
    push_cmd(OP_ADD, 8'd3, 8'd4, 4'd2);
    push_cmd(OP_ADD, 8'd5, 8'd6, 4'd3);
    step(2);
    check("pre_rst_count", 32'(bus.fifo_count), 32'd2);
    check("pre_rst_valid", 32'(bus.rsp_valid),  32'd0);
    reset = 1'b1;
    step();
    check("mid_rst_count", 32'(bus.fifo_count), 32'd0);
    check("mid_rst_valid", 32'(bus.rsp_valid),  32'd0);
    check("mid_rst_start", 32'(bus.alu_start),  32'd0);
    check("mid_rst_ready", 32'(bus.cmd_ready),  32'd1);
    reset = 1'b0;
    s0 = n_start;
    seen = 0;
    for (int i = 0; i < 3*TMO; i++) begin
      step();
      if (bus.rsp_valid) seen = 1;
    end
    check("abandon_no_rsp",   32'(seen), 32'd0);
    check("abandon_no_start", 32'(n_start - s0), 32'd0);

    // Randomized traffic against a queue-based reference
    mode = STUB_NORMAL;
    s0 = n_start;
    accepted = 0;
    for (int c = 0; c < 800; c++) begin
      bus.cmd_valid = ($urandom_range(0, 2) != 0);
      bus.cmd_op    = 3'($urandom);
      bus.cmd_a     = 8'($urandom);
      bus.cmd_b     = 8'($urandom);
      bus.cmd_tag   = TAG_W'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (bus.cmd_valid && bus.cmd_ready) begin
        exp_q.push_back('{bus.cmd_op, bus.cmd_tag,
                          alu_ref(bus.cmd_op, bus.cmd_a, bus.cmd_b), 1'b0});
        accepted++;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rand_rsp", {5'(bus.rsp_op), 3'(bus.rsp_tag), bus.rsp_result, 7'h0, bus.rsp_timeout},
                {5'(e.op), 3'(e.tag), e.result, 7'h0, e.timeout});
        end
      end
      step();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 2000 && exp_q.size() != 0; c++) begin
      if (bus.rsp_valid) begin
        e = exp_q.pop_front();
        check("drain_rsp", {5'(bus.rsp_op), 3'(bus.rsp_tag), bus.rsp_result, 7'h0, bus.rsp_timeout},
              {5'(e.op), 3'(e.tag), e.result, 7'h0, e.timeout});
      end
      step();
    end
    check("rand_all_returned", 32'(exp_q.size()), 32'd0);
    check("rand_starts", 32'(n_start - s0), 32'(accepted));
    check("no_double_start", 32'(n_double), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
